// File: rtl/pause_sched_if.sv
// Pause scheduler handshake bundle: pause sources and vblank/step in, CPU halt, dim and source snapshot out.
interface pause_sched_if #(
  parameter int NREQ = 4
);
  logic            user_button;
  logic [NREQ-1:0] req;
  logic            osd_status;
  logic [1:0]      options;
  logic            vblank;
  logic            step;
  logic            pause_cpu;
  logic            paused;
  logic            dim_video;
  logic [NREQ+1:0] src;

  modport master (
    output user_button, req, osd_status, options, vblank, step,
    input  pause_cpu, paused, dim_video, src
  );

  modport slave (
    input  user_button, req, osd_status, options, vblank, step,
    output pause_cpu, paused, dim_video, src
  );
endinterface

// File: rtl/pause_sched.sv
// Pause scheduler: halts the CPU on a vblank boundary while any pause source is active, with idle dimming.
// Define PAUSE_SCHED_STEP_EN to enable single-frame stepping while paused.
module pause_sched #(
  parameter int          NREQ       = 4,
  parameter int          CLKSPD     = 12,
  parameter int          DIM_SECS   = 10,
  parameter int          VB_TIMEOUT = CLKSPD * 20000,
  parameter int unsigned DIM_MAX    = CLKSPD * DIM_SECS * 1000000
) (
  input  logic          clk_sys,
  input  logic          reset,
  pause_sched_if.slave  io
);

  typedef enum logic [1:0] {RUN, PEND, PAUSED, STEP} state_e;

  localparam logic [31:0] VB_LAST = 32'(VB_TIMEOUT - 1);
  localparam logic [31:0] DIM_SAT = 32'(DIM_MAX);

  state_e          state_q, state_d;
  logic [31:0]     wait_q, wait_d;
  logic [31:0]     dim_q, dim_d;
  logic            user_latch_q, user_latch_d;
  logic            btn_q, btn_d;
  logic            vblank_q, vblank_d;
  logic            pause_cpu_q, pause_cpu_d;
  logic            dim_video_q, dim_video_d;
  logic [NREQ+1:0] src_q, src_d;

  logic osd_term, btn_rise, vb_rise, any_req;

  always_comb begin
    osd_term     = io.osd_status & io.options[0];
    btn_rise     = io.user_button & ~btn_q;
    vb_rise      = io.vblank & ~vblank_q;
    any_req      = (|io.req) | user_latch_q | osd_term;
    btn_d        = io.user_button;
    vblank_d     = io.vblank;
    user_latch_d = user_latch_q ^ btn_rise;
    src_d        = {osd_term, user_latch_q, io.req};
  end

  // Wait counter only runs in PEND so every entry into PEND starts from zero.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      RUN:    if (any_req) state_d = PEND;
      PEND: begin
        wait_d = wait_q + 32'd1;
        if (!any_req)                         state_d = RUN;
        else if (vb_rise || wait_q == VB_LAST) state_d = PAUSED;
      end
      PAUSED: begin
        if (!any_req) state_d = RUN;
`ifdef PAUSE_SCHED_STEP_EN
        else if (io.step) state_d = STEP;
`endif
      end
`ifdef PAUSE_SCHED_STEP_EN
      STEP:   if (vb_rise) state_d = any_req ? PAUSED : RUN;
`endif
      default: state_d = RUN;
    endcase
  end

`ifndef PAUSE_SCHED_STEP_EN
  logic unused_step;
  assign unused_step = io.step;
`endif

  // Dim time counts only across edges that stay in PAUSED, so leaving PAUSED drops dim at once.
  always_comb begin
    pause_cpu_d = (state_q == PAUSED);
    dim_d       = '0;
    if (state_q == PAUSED && state_d == PAUSED && io.options[1])
      dim_d = (dim_q == DIM_SAT) ? dim_q : dim_q + 32'd1;
    dim_video_d = (dim_d == DIM_SAT);
  end

  // Edge detectors track their inputs through reset so a held button or vblank is not seen as a new edge.
  always_ff @(posedge clk_sys) begin
    btn_q    <= btn_d;
    vblank_q <= vblank_d;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= RUN;
      wait_q       <= '0;
      dim_q        <= '0;
      user_latch_q <= 1'b0;
      pause_cpu_q  <= 1'b0;
      dim_video_q  <= 1'b0;
      src_q        <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      dim_q        <= dim_d;
      user_latch_q <= user_latch_d;
      pause_cpu_q  <= pause_cpu_d;
      dim_video_q  <= dim_video_d;
      src_q        <= src_d;
    end
  end

  assign io.pause_cpu = pause_cpu_q;
  assign io.paused    = (state_q == PAUSED);
  assign io.dim_video = dim_video_q;
  assign io.src       = src_q;

endmodule

// File: tb/tb_pause_sched.sv
// Directed bench for pause_sched: vblank/timeout entry, step, OSD gating, dimming, button latch and reset.
module tb_pause_sched;
  localparam int NREQ = 4;
  localparam int VBT  = 1000;
  localparam int DIMM = 300;
`ifdef PAUSE_SCHED_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset;
  int   vec = 0;
  int   err = 0;

  pause_sched_if #(.NREQ(NREQ)) bus();

  pause_sched #(
    .NREQ(NREQ), .CLKSPD(12), .DIM_SECS(10), .VB_TIMEOUT(VBT), .DIM_MAX(DIMM)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .io     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    vec++; if (bus.pause_cpu !== 1'b0) begin err++; $display("FAIL rst_pause_cpu: got %b want 0", bus.pause_cpu); end
    vec++; if (bus.paused !== 1'b0) begin err++; $display("FAIL rst_paused: got %b want 0", bus.paused); end
    vec++; if (bus.dim_video !== 1'b0) begin err++; $display("FAIL rst_dim: got %b want 0", bus.dim_video); end
    vec++; if (bus.src !== 6'h00) begin err++; $display("FAIL rst_src: got %h want 00", bus.src); end
    bus.user_button = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    vec++; if (bus.src !== 6'h00) begin err++; $display("FAIL rst_btn_src: got %h want 00", bus.src); end
    vec++; if (bus.paused !== 1'b0) begin err++; $display("FAIL rst_btn_paused: got %b want 0", bus.paused); end
    bus.user_button = 1'b0;
    tick(1);
  endtask

  task automatic test_vblank;
    bus.req = 4'b0010;
    tick(500);
    vec++; if (bus.pause_cpu !== 1'b0) begin err++; $display("FAIL vb_pend_cpu: got %b want 0", bus.pause_cpu); end
    vec++; if (bus.paused !== 1'b0) begin err++; $display("FAIL vb_pend_paused: got %b want 0", bus.paused); end
    vec++; if (bus.src !== 6'h02) begin err++; $display("FAIL vb_src: got %h want 02", bus.src); end
    bus.vblank = 1'b1;
    tick(1);
    vec++; if (bus.paused !== 1'b1) begin err++; $display("FAIL vb_paused: got %b want 1", bus.paused); end
    vec++; if (bus.pause_cpu !== 1'b0) begin err++; $display("FAIL vb_cpu_lag: got %b want 0", bus.pause_cpu); end
    tick(1);
    vec++; if (bus.pause_cpu !== 1'b1) begin err++; $display("FAIL vb_cpu: got %b want 1", bus.pause_cpu); end
    bus.vblank = 1'b0;
    bus.req = 4'b0000;
    tick(2);
    vec++; if (bus.paused !== 1'b0) begin err++; $display("FAIL vb_release_paused: got %b want 0", bus.paused); end
    vec++; if (bus.pause_cpu !== 1'b0) begin err++; $display("FAIL vb_release_cpu: got %b want 0", bus.pause_cpu); end
  endtask

  task automatic test_timeout;
    bus.req = 4'b0001;
    tick(VBT);
    vec++; if (bus.paused !== 1'b0) begin err++; $display("FAIL to_early: got %b want 0", bus.paused); end
    tick(1);
    vec++; if (bus.paused !== 1'b1) begin err++; $display("FAIL to_paused: got %b want 1", bus.paused); end
    tick(1);
    vec++; if (bus.pause_cpu !== 1'b1) begin err++; $display("FAIL to_cpu: got %b want 1", bus.pause_cpu); end
  endtask

  task automatic test_step;
    bus.step = 1'b1;
    tick(1);
    bus.step = 1'b0;
    vec++; if (bus.paused !== !STEP_EN) begin err++; $display("FAIL step_paused: got %b want %b", bus.paused, !STEP_EN); end
    tick(1);
    vec++; if (bus.pause_cpu !== !STEP_EN) begin err++; $display("FAIL step_cpu: got %b want %b", bus.pause_cpu, !STEP_EN); end
    bus.step = 1'b1;
    tick(1);
    bus.step = 1'b0;
    tick(3);
    vec++; if (bus.pause_cpu !== !STEP_EN) begin err++; $display("FAIL step_ignore: got %b want %b", bus.pause_cpu, !STEP_EN); end
    bus.vblank = 1'b1;
    tick(1);
    vec++; if (bus.paused !== 1'b1) begin err++; $display("FAIL step_vb_paused: got %b want 1", bus.paused); end
    tick(1);
    vec++; if (bus.pause_cpu !== 1'b1) begin err++; $display("FAIL step_vb_cpu: got %b want 1", bus.pause_cpu); end
    bus.vblank = 1'b0;
    tick(1);
    bus.vblank = 1'b1;
    tick(1);
    bus.vblank = 1'b0;
    tick(2);
    vec++; if (bus.pause_cpu !== 1'b1) begin err++; $display("FAIL step_vb2_cpu: got %b want 1", bus.pause_cpu); end
    vec++; if (bus.paused !== 1'b1) begin err++; $display("FAIL step_vb2_paused: got %b want 1", bus.paused); end
  endtask

  task automatic test_osd;
    bus.req = 4'b0000;
    tick(2);
    vec++; if (bus.paused !== 1'b0) begin err++; $display("FAIL osd_idle: got %b want 0", bus.paused); end
    bus.osd_status = 1'b1;
    bus.options = 2'b00;
    tick(2);
    bus.vblank = 1'b1;
    tick(1);
    bus.vblank = 1'b0;
    tick(1);
    vec++; if (bus.paused !== 1'b0) begin err++; $display("FAIL osd_off_paused: got %b want 0", bus.paused); end
    vec++; if (bus.src !== 6'h00) begin err++; $display("FAIL osd_off_src: got %h want 00", bus.src); end
    bus.options = 2'b01;
    tick(1);
    vec++; if (bus.src !== 6'h20) begin err++; $display("FAIL osd_on_src: got %h want 20", bus.src); end
    bus.vblank = 1'b1;
    tick(1);
    bus.vblank = 1'b0;
    vec++; if (bus.paused !== 1'b1) begin err++; $display("FAIL osd_on_paused: got %b want 1", bus.paused); end
    bus.step = 1'b1;
    bus.osd_status = 1'b0;
    tick(1);
    bus.step = 1'b0;
    vec++; if (bus.paused !== 1'b0) begin err++; $display("FAIL prio_exit: got %b want 0", bus.paused); end
    bus.osd_status = 1'b1;
    tick(VBT + 3);
    vec++; if (bus.paused !== 1'b1) begin err++; $display("FAIL prio_run_path: got %b want 1", bus.paused); end
  endtask

  task automatic test_dim;
    bus.req = 4'b0001;
    bus.options = 2'b10;
    tick(DIMM - 1);
    vec++; if (bus.dim_video !== 1'b0) begin err++; $display("FAIL dim_early: got %b want 0", bus.dim_video); end
    vec++; if (bus.paused !== 1'b1) begin err++; $display("FAIL dim_paused: got %b want 1", bus.paused); end
    tick(1);
    vec++; if (bus.dim_video !== 1'b1) begin err++; $display("FAIL dim_on: got %b want 1", bus.dim_video); end
    tick(5);
    vec++; if (bus.dim_video !== 1'b1) begin err++; $display("FAIL dim_sat: got %b want 1", bus.dim_video); end
    bus.options = 2'b00;
    tick(1);
    vec++; if (bus.dim_video !== 1'b0) begin err++; $display("FAIL dim_opt_off: got %b want 0", bus.dim_video); end
    bus.options = 2'b10;
    tick(DIMM);
    vec++; if (bus.dim_video !== 1'b1) begin err++; $display("FAIL dim_restart: got %b want 1", bus.dim_video); end
    bus.req = 4'b0000;
    bus.osd_status = 1'b0;
    tick(1);
    vec++; if (bus.dim_video !== 1'b0) begin err++; $display("FAIL dim_drop: got %b want 0", bus.dim_video); end
    vec++; if (bus.paused !== 1'b0) begin err++; $display("FAIL dim_drop_paused: got %b want 0", bus.paused); end
    bus.options = 2'b00;
    tick(2);
  endtask

  task automatic test_button;
    bus.user_button = 1'b1;
    tick(100);
    vec++; if (bus.src !== 6'h10) begin err++; $display("FAIL btn_hold: got %h want 10", bus.src); end
    bus.user_button = 1'b0;
    tick(3);
    vec++; if (bus.src !== 6'h10) begin err++; $display("FAIL btn_release: got %h want 10", bus.src); end
    bus.user_button = 1'b1;
    tick(1);
    bus.user_button = 1'b0;
    tick(2);
    vec++; if (bus.src !== 6'h00) begin err++; $display("FAIL btn_toggle_off: got %h want 00", bus.src); end
    bus.user_button = 1'b1;
    tick(1);
    bus.user_button = 1'b0;
    tick(2);
    bus.vblank = 1'b1;
    tick(1);
    bus.vblank = 1'b0;
    vec++; if (bus.paused !== 1'b1) begin err++; $display("FAIL btn_paused: got %b want 1", bus.paused); end
    tick(1);
    vec++; if (bus.pause_cpu !== 1'b1) begin err++; $display("FAIL btn_cpu: got %b want 1", bus.pause_cpu); end
    bus.req = 4'b1000;
    reset = 1'b1;
    tick(1);
    vec++; if (bus.pause_cpu !== 1'b0) begin err++; $display("FAIL rst_mid_cpu: got %b want 0", bus.pause_cpu); end
    vec++; if (bus.src !== 6'h00) begin err++; $display("FAIL rst_mid_src: got %h want 00", bus.src); end
    reset = 1'b0;
    tick(2);
    vec++; if (bus.src !== 6'h08) begin err++; $display("FAIL rst_latch_clear: got %h want 08", bus.src); end
    bus.vblank = 1'b1;
    tick(1);
    bus.vblank = 1'b0;
    vec++; if (bus.paused !== 1'b1) begin err++; $display("FAIL rst_repend: got %b want 1", bus.paused); end
  endtask

  initial begin
    reset           = 1'b1;
    bus.user_button = 1'b0;
    bus.req         = '0;
    bus.osd_status  = 1'b0;
    bus.options     = 2'b00;
    bus.vblank      = 1'b0;
    bus.step        = 1'b0;
    test_reset;
    test_vblank;
    test_timeout;
    test_step;
    test_osd;
    test_dim;
    test_button;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/pause_sched.md
PAUSE_SCHED -- requirements
Module: pause_sched

Interface
REQ-001 Parameter NREQ, default 4: number of external level pause requesters.
REQ-002 Parameter CLKSPD, default 12: clk_sys frequency in MHz.
REQ-003 Parameter DIM_SECS, default 10: seconds paused before dim_video asserts.
REQ-004 Parameter VB_TIMEOUT, default CLKSPD*20000: cycles to wait for vblank before forcing pause (20 ms).
REQ-005 clk_sys  in  1  core system clock; single clock domain.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 user_button  in  1  user pause button, active-high; rising edge toggles the user pause latch.
REQ-008 req  in  NREQ  level pause requests (hiscore, debugger, etc.), active-high.
REQ-009 osd_status  in  1  OSD open, active-high.
REQ-010 options  in  2  bit0 = pause while OSD open; bit1 = dim enable.
REQ-011 vblank  in  1  video vertical blank, clk_sys-synchronous.
REQ-012 step  in  1  single-cycle pulse requesting a one-frame advance while paused.
REQ-013 pause_cpu  out  1  registered halt to CPU, active-high.
REQ-014 paused  out  1  high only in state PAUSED.
REQ-015 dim_video  out  1  registered dim request to the video path.
REQ-016 src  out  NREQ+2  registered snapshot of active sources: {osd_term, user_latch, req}.

Function
REQ-017 any_req SHALL be |req OR user_latch OR (osd_status AND options[0]), evaluated combinationally each cycle.
REQ-018 vb_rise SHALL be vblank AND NOT vblank registered one cycle earlier.
REQ-019 FSM states SHALL be RUN, PEND, PAUSED, STEP; all transitions take effect on the next clk_sys edge.
REQ-020 RUN: pause_cpu=0; any_req -> PEND.
REQ-021 PEND: pause_cpu=0; wait counter increments; !any_req -> RUN (priority); else vb_rise or counter reaching VB_TIMEOUT-1 -> PAUSED; counter cleared in every other state.
REQ-022 PAUSED: pause_cpu=1; !any_req -> RUN (priority over step); else step -> STEP.
REQ-023 STEP: pause_cpu=0; the first vb_rise observed in STEP -> PAUSED if any_req, else RUN; step pulses received in STEP are ignored.
REQ-024 A user_button rising edge SHALL toggle user_latch in any state; it is an edge on a registered copy of the input, so holding the button produces exactly one toggle.
REQ-025 src SHALL update every cycle with the current source terms.
REQ-026 The dim counter (32 bit) SHALL increment in PAUSED while options[1]=1, saturate at CLKSPD*DIM_SECS*1000000, and clear in any other state or when options[1]=0.
REQ-027 dim_video SHALL be 1 when the counter is at the saturation value, else 0.
REQ-028 Latency: PEND->PAUSED with pause_cpu=1 SHALL occur one cycle after the clock edge at which vb_rise is sampled.

Reset
REQ-029 Reset SHALL force state RUN, user_latch=0, pause_cpu=0, paused=0, dim_video=0, src=0, and both counters=0; reset overrides every other input, including a simultaneous user_button edge.
REQ-030 Reset mid-pause or mid-step SHALL release the CPU on the following cycle; level requests still high re-enter PEND after reset deasserts.

Configuration
REQ-031 With macro PAUSE_SCHED_STEP_EN defined, REQ-022/023 step behaviour SHALL be present.
REQ-032 Without PAUSE_SCHED_STEP_EN, the step port SHALL remain, its value SHALL be ignored, STEP SHALL be unreachable, and PAUSED SHALL exit only on !any_req.

Verification
REQ-033 req[1]=1 held, vblank rises 500 cycles later -> pause_cpu=0 until the edge after the vb_rise sample, then 1; paused=1; src[1]=1.
REQ-034 req[0]=1, vblank held 0 -> PAUSED after exactly VB_TIMEOUT cycles in PEND (240000 at CLKSPD=12).
REQ-035 Paused, step pulse, two vblank rises -> pause_cpu=0 from the next cycle until the first vb_rise, then 1; second vb_rise -> no change; with the macro off -> pause_cpu stays 1.
REQ-036 Paused, options=2'b10, CLKSPD=1, DIM_SECS=1 -> dim_video rises after 1000000 cycles in PAUSED; req drop -> dim_video=0 next cycle.
REQ-037 user_button held high 100 cycles -> exactly one toggle; reset asserted while paused -> pause_cpu=0 and user_latch=0 on the next edge.
REQ-038 osd_status=1, options[0]=0 -> no pause; options[0]=1 -> PEND; step and !any_req in the same PAUSED cycle -> RUN.
